// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: rotates one grant among N requesters using a masked
// lowest-set-bit pick, holds it until DONE, request drop or the hold limit.
module round_robin_arbiter #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 0
) (
  input  logic           CLK,
  input  logic           RESETN,
  input  logic [N-1:0]   REQ,
  input  logic           DONE,
  output logic [N-1:0]   GNT,
  output logic           GNT_VALID,
  output logic [IDW-1:0] GNT_ID,
  output logic           GNT_EXPIRED
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  last, last_nxt;
  logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
  logic [N-1:0]    gnt_nxt;
  logic [IDW-1:0]  gnt_id_nxt;
  logic            expired_nxt;

  logic [N-1:0]    mask;
  logic [N-1:0]    pick;
  logic            limit_hit;
  logic            holder_req;

  function automatic logic [N-1:0] lowbit(input logic [N-1:0] v);
    return v & ~(v - N'(1));
  endfunction

  function automatic logic [IDW-1:0] onehot_index(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) idx = idx | IDW'(i);
    return idx;
  endfunction

  // Requesters strictly above the previous winner get first pick; if none, wrap to the raw vector.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = (IDW'(i) > last);
    pick = ((REQ & mask) != '0) ? lowbit(REQ & mask) : lowbit(REQ);
  end

  assign limit_hit  = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
  assign holder_req = REQ[GNT_ID];

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = GNT;
    gnt_id_nxt   = GNT_ID;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    expired_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (|REQ) begin
          gnt_nxt      = pick;
          gnt_id_nxt   = onehot_index(pick);
          hold_cnt_nxt = HW'(1);
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (DONE || !holder_req || limit_hit) begin
          // Expiry is reported only when the hold limit was the sole cause.
          expired_nxt  = limit_hit && !DONE && holder_req;
          gnt_nxt      = '0;
          gnt_id_nxt   = '0;
          last_nxt     = GNT_ID;
          hold_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else if (MAX_HOLD != 0 && hold_cnt != HW'(MAX_HOLD)) begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state       <= IDLE;
      GNT         <= '0;
      GNT_VALID   <= 1'b0;
      GNT_ID      <= '0;
      GNT_EXPIRED <= 1'b0;
      last        <= IDW'(N - 1);
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      GNT         <= gnt_nxt;
      GNT_VALID   <= |gnt_nxt;
      GNT_ID      <= gnt_id_nxt;
      GNT_EXPIRED <= expired_nxt;
      last        <= last_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed-vector bench for round_robin_arbiter (N=8, MAX_HOLD=4) with a
// queue-based scoreboard checked one cycle after each driven edge.
module tb_round_robin_arbiter;
  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int MAX_HOLD = 4;

  logic           CLK = 1'b0;
  logic           RESETN;
  logic [N-1:0]   REQ;
  logic           DONE;
  logic [N-1:0]   GNT;
  logic           GNT_VALID;
  logic [IDW-1:0] GNT_ID;
  logic           GNT_EXPIRED;

  round_robin_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .DONE(DONE),
    .GNT(GNT), .GNT_VALID(GNT_VALID), .GNT_ID(GNT_ID), .GNT_EXPIRED(GNT_EXPIRED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rstn;
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic       x;
  } vec_t;

  typedef struct {
    int         step;
    logic [7:0] g;
    logic       x;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic [7:0] q, input logic d,
                     input logic [7:0] g, input logic x);
    vec_t v;
    v.rstn = r; v.req = q; v.done = d; v.g = g; v.x = x;
    vecs.push_back(v);
  endtask

  // Monitor: one expected entry per driven edge, compared #1 after that edge.
  initial begin
    exp_t           e;
    logic [IDW-1:0] want_id;
    forever begin
      @(posedge CLK);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        want_id = '0;
        for (int i = 0; i < N; i++)
          if (e.g[i]) want_id = IDW'(i);
        checks++;
        if (GNT === e.g && GNT_VALID === (|e.g) && GNT_ID === want_id && GNT_EXPIRED === e.x)
          passed++;
        else
          $display("FAIL step%0d: got gnt=%h vld=%b id=%0d expired=%b, want gnt=%h vld=%b id=%0d expired=%b",
                   e.step, GNT, GNT_VALID, GNT_ID, GNT_EXPIRED, e.g, |e.g, want_id, e.x);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    exp_t e;
    RESETN = 1'b0;
    REQ    = '0;
    DONE   = 1'b0;

    // Reset held with all requests, then requester 0 wins first
    add(0, 8'hFF, 0, 8'h00, 0);
    add(0, 8'hFF, 0, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h01, 0);
    // Rotation with DONE each grant, one idle cycle between grants
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h02, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h04, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h08, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h10, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h20, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h40, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h80, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h01, 0);
    add(1, 8'hFF, 1, 8'h00, 0);
    // Mask and wrap: make last=5, then 8'h21 wraps to bit 0, then bit 5
    add(1, 8'h20, 0, 8'h20, 0);
    add(1, 8'h20, 1, 8'h00, 0);
    add(1, 8'h21, 0, 8'h01, 0);
    add(1, 8'h21, 1, 8'h00, 0);
    add(1, 8'h21, 0, 8'h20, 0);
    add(1, 8'h21, 1, 8'h00, 0);
    // Request drop releases without DONE; next round picks bit 3
    add(1, 8'h04, 0, 8'h04, 0);
    add(1, 8'h09, 0, 8'h00, 0);
    add(1, 8'h09, 0, 8'h08, 0);
    add(1, 8'h09, 1, 8'h00, 0);
    add(1, 8'h00, 0, 8'h00, 0);
    add(1, 8'h00, 1, 8'h00, 0);
    // Hold limit: 4 grant cycles, then an expiry pulse
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 0, 8'h00, 1);
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h03, 0, 8'h00, 1);
    // DONE coinciding with the limit is a normal release
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 0, 8'h01, 0);
    add(1, 8'h03, 1, 8'h00, 0);
    // Request drop coinciding with the limit is a normal release
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h03, 0, 8'h02, 0);
    add(1, 8'h01, 0, 8'h00, 0);
    // Lone requester re-granted; request changes during a grant ignored
    add(1, 8'h01, 0, 8'h01, 0);
    add(1, 8'h01, 1, 8'h00, 0);
    add(1, 8'h01, 0, 8'h01, 0);
    add(1, 8'h81, 0, 8'h01, 0);
    add(1, 8'h81, 1, 8'h00, 0);
    // Reset mid-grant drops the grant and restores requester-0 priority
    add(1, 8'h10, 0, 8'h10, 0);
    add(0, 8'h10, 0, 8'h00, 0);
    add(1, 8'h11, 0, 8'h01, 0);
    add(1, 8'h11, 1, 8'h00, 0);

    foreach (vecs[k]) begin
      @(negedge CLK);
      RESETN = vecs[k].rstn;
      REQ    = vecs[k].req;
      DONE   = vecs[k].done;
      e.step = k;
      e.g    = vecs[k].g;
      e.x    = vecs[k].x;
      expq.push_back(e);
    end
    @(negedge CLK);
    REQ  = '0;
    DONE = 1'b0;
    @(posedge CLK);
    #3;
    checks++;
    if (expq.size() == 0 && checks == vecs.size() + 1)
      passed++;
    else
      $display("FAIL drain: pending=%0d compared=%0d, want pending=0 compared=%0d",
               expq.size(), checks - 1, vecs.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
